// File: rtl/audio_pkg.sv
// Shared audio types for the SPI receiver, effect, path controller and DAC driver.
// Samples are signed 16-bit PCM; the path FSM states live here.
package audio_pkg;
  typedef logic signed [15:0] sample_t;
  typedef enum logic [1:0] {IDLE, START, WAIT, SEND} path_state_t;
endpackage

// File: rtl/audio_path_ctrl.sv
// Routes each sample through the effect or a bypass path to the DAC,
// with a one-entry pending slot, saturating drop counter and effect watchdog.
module audio_path_ctrl
  import audio_pkg::*;
#(
  parameter int clock_max   = 25_000_000,
  parameter int EFF_TIMEOUT = 256,
  parameter int DROP_W      = 8
) (
  input  logic              clk_25mhz,
  input  logic              reset,
  input  logic              in_valid,
  input  sample_t           in_sample,
  input  logic              bypass,
  output logic              eff_start,
  output sample_t           eff_sample,
  input  logic              eff_done,
  input  sample_t           eff_result,
  output logic              dac_valid,
  output sample_t           dac_sample,
  input  logic              dac_ready,
  output logic              busy,
  output logic [DROP_W-1:0] drop_count,
  output logic              timeout_flag
);

  localparam int TW = $clog2(EFF_TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(EFF_TIMEOUT - 1);

  if (clock_max <= 0 || EFF_TIMEOUT < 2) begin : g_bad_param
    $error("audio_path_ctrl: bad clock_max or EFF_TIMEOUT");
  end

  path_state_t       state_q;
  sample_t           work_q;
  sample_t           pend_q;
  logic              pend_byp_q;
  logic              pend_vld_q;
  logic [TW-1:0]     timer_q;
  logic [DROP_W-1:0] drop_q;
  logic              tflag_q;
  logic              eff_start_q;
  logic              dac_valid_q;

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      pend_q      <= '0;
      pend_byp_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      timer_q     <= '0;
      drop_q      <= '0;
      tflag_q     <= 1'b0;
      eff_start_q <= 1'b0;
      dac_valid_q <= 1'b0;
    end else begin
      eff_start_q <= 1'b0;
      // Arrivals while a sample is in flight go to pending or are dropped
      if (in_valid && state_q != IDLE) begin
        if (!pend_vld_q) begin
          pend_q     <= in_sample;
          pend_byp_q <= bypass;
          pend_vld_q <= 1'b1;
        end else if (drop_q != '1) begin
          drop_q <= drop_q + 1'b1;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (pend_vld_q) begin
            work_q     <= pend_q;
            pend_vld_q <= in_valid;
            if (in_valid) begin
              pend_q     <= in_sample;
              pend_byp_q <= bypass;
            end
            if (pend_byp_q) begin
              state_q     <= SEND;
              dac_valid_q <= 1'b1;
            end else begin
              state_q     <= START;
              eff_start_q <= 1'b1;
            end
          end else if (in_valid) begin
            work_q <= in_sample;
            if (bypass) begin
              state_q     <= SEND;
              dac_valid_q <= 1'b1;
            end else begin
              state_q     <= START;
              eff_start_q <= 1'b1;
            end
          end
        end
        START: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          timer_q <= timer_q + 1'b1;
          if (eff_done) begin
            work_q      <= eff_result;
            state_q     <= SEND;
            dac_valid_q <= 1'b1;
          end else if (timer_q == T_LAST) begin
            tflag_q     <= 1'b1;
            state_q     <= SEND;
            dac_valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (dac_ready) begin
            dac_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign eff_start    = eff_start_q;
  assign eff_sample   = work_q;
  assign dac_valid    = dac_valid_q;
  assign dac_sample   = work_q;
  assign busy         = (state_q != IDLE);
  assign drop_count   = drop_q;
  assign timeout_flag = tflag_q;

endmodule
